// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding, defaults and helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACCEPT     = 3'd1,
        SEND       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } state_t;
    localparam int START_TIMEOUT_DEF = 16;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter side signals of the UART TX arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4, parameter int ID_W = 2);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx_en;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_busy;
    logic                 gnt_valid;
    logic [ID_W-1:0]      gnt_id;
    logic                 arb_busy;
    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_tx_en, uart_tx_data, gnt_valid, gnt_id, arb_busy
    );
    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_tx_en, uart_tx_data, gnt_valid, gnt_id, arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set bit at or above ptr with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         hit
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
    end
    assign hit = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among NUM_REQ requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CW = clog2(START_TIMEOUT + 1);
    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, gnt_id_q, gnt_id_d, pick;
    logic            gnt_valid_q, gnt_valid_d, last_q, last_d, hit, go;
    logic [7:0]      data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req(bus.req_valid),
        .ptr(ptr_q),
        .idx(pick),
        .hit(hit)
    );

    assign go      = state_q == ACCEPT && bus.req_valid[gnt_id_q] && !bus.uart_tx_busy;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        last_d      = last_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (hit) begin
                gnt_id_d    = pick;
                gnt_valid_d = 1'b1;
                state_d     = ACCEPT;
            end
            ACCEPT: if (go) begin
                data_d  = bus.req_data[8*gnt_id_q +: 8];
                last_d  = bus.req_last[gnt_id_q];
                state_d = SEND;
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                cnt_d   = cnt_inc;
                state_d = (bus.uart_tx_busy || cnt_inc >= CW'(START_TIMEOUT - 1)) ? WAIT_DONE : WAIT_START;
            end
            WAIT_DONE: if (!bus.uart_tx_busy) begin
                state_d     = last_q ? IDLE : ACCEPT;
                gnt_valid_d = !last_q;
                ptr_d       = !last_q ? ptr_q : (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            last_q      <= last_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready    = go ? NUM_REQ'(1) << gnt_id_q : '0;
    assign bus.uart_tx_en   = state_q == SEND;
    assign bus.uart_tx_data = data_q;
    assign bus.gnt_valid    = gnt_valid_q;
    assign bus.gnt_id       = gnt_id_q;
    assign bus.arb_busy     = state_q != IDLE;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with packet lock. A requester that wins the grant keeps it until its byte flagged last has been sent. The block sits between requester logic (command responders, status reporters) and the uart_tx instance. It sequences each byte through the transmitter's enable/busy handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant index; must equal clog2(NUM_REQ)
START_TIMEOUT, 16, max cycles to wait for uart_tx_busy to rise after a send pulse before treating the byte as sent

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the final byte of the requester's packet
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
uart_tx_en  out  1  one-cycle send pulse to the transmitter
uart_tx_data  out  8  byte to send; held stable from the pulse until the next accept
uart_tx_busy  in  1  transmitter busy, high while a frame is on the line
gnt_valid  out  1  a packet is locked to a requester
gnt_id  out  ID_W  index of the locked requester, valid while gnt_valid=1
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1) puts the block in IDLE with all outputs 0, the round-robin pointer at 0, and the timeout counter at 0.
- States: IDLE, ACCEPT, SEND, WAIT_START, WAIT_DONE.
- IDLE: if any req_valid is set, pick the first set bit searching from the pointer upward with wrap. Latch its index into gnt_id, set gnt_valid=1, go to ACCEPT. Arbitration costs 1 cycle.
- ACCEPT: if req_valid[gnt_id]=1 and uart_tx_busy=0:
  - pulse req_ready[gnt_id] for 1 cycle;
  - latch req_data slice into uart_tx_data and req_last into an internal last_f;
  - go to SEND.
  Otherwise stay in ACCEPT. The lock holds even if valid drops mid-packet. No other requester is served until last is sent.
- SEND: uart_tx_en=1 for exactly 1 cycle. Clear the timeout counter. Go to WAIT_START.
- WAIT_START: if uart_tx_busy=1, go to WAIT_DONE. Otherwise count; when the count reaches START_TIMEOUT-1, go to WAIT_DONE. This covers transmitters whose busy flag lags or is absent.
- WAIT_DONE: when uart_tx_busy=0:
  - if last_f=1: set gnt_valid=0, set pointer=(gnt_id+1) mod NUM_REQ, go to IDLE;
  - else go to ACCEPT.
- Latency:
  - request to first uart_tx_en: 3 cycles from IDLE (arbitrate, accept, send);
  - byte-to-byte within a packet: 2 cycles after busy falls.
- At most one req_ready bit is high in any cycle. req_ready is never asserted outside ACCEPT.
- uart_tx_data is unchanged between ACCEPT cycles.
- Simultaneous requests: the lowest index at or above the pointer wins. The pointer only advances at packet end, which gives fairness per packet, not per byte.
- Single-byte packet (req_last=1 on first byte): one accept, one send, release.
- Index arithmetic wraps modulo NUM_REQ. For a non-power-of-2 NUM_REQ, indices at or above NUM_REQ are never generated.
- Reset mid-packet: everything returns to IDLE immediately. The transmitter's partial frame is not the arbiter's concern. The requester must restart its packet after reset.
- uart_tx_busy already high in ACCEPT (external sender or previous frame still draining): the block waits and does not accept.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=0, ACCEPT=1, SEND=2, WAIT_START=3, WAIT_DONE=4, 3-bit);
  - START_TIMEOUT default;
  - a clog2 constant function.
- One sub-module: rr_pick (combinational round-robin priority encoder). Inputs: req vector and pointer. Outputs: winner index and any-hit flag. It is reusable by future arbiters.

Test Plan:
- Single requester: req 0 sends 0x41 then 0x42 (last), with a busy model of 10 cycles.
  - Expect exactly two uart_tx_en pulses with data 0x41 and 0x42 in order.
  - Expect two req_ready[0] pulses.
  - Expect gnt_valid to fall after the second busy fall.
- Contention: reqs 0, 1 and 3 each hold a 2-byte packet (0x10/0x11, 0x20/0x21, 0x30/0x31) valid from the same cycle, pointer at 0.
  - Expect byte order 10,11,20,21,30,31.
  - Expect gnt_id sequence 0,1,3.
- Fairness: req 0 has back-to-back single-byte packets and req 2 has one packet.
  - Expect req 2 served before req 0's second packet.
- Packet lock with stall: req 1 drops valid for 20 cycles after its first byte while req 0 is valid.
  - Expect gnt_id to stay 1 and no req_ready[0] until req 1's last byte is sent.
- Missing busy: tie uart_tx_busy=0 and send 3 bytes.
  - Expect consecutive uart_tx_en pulses spaced exactly START_TIMEOUT+2 cycles.
- Reset: assert rst in WAIT_DONE mid-packet.
  - Expect all outputs 0 in the same cycle and the pointer back at 0.
  - After release, the next request from req 2 wins with gnt_id=2.
